// File: rtl/store_buffer_pkg.sv
// Shared definitions for the MEM-stage store buffer.
//   STORE_TYPE_SIZE : width of the store-type field carried with each store
//   ST_WORD/HALF/BYTE : store-type codes as issued by the decoder
//   SB_DEPTH        : default number of buffer entries
package store_buffer_pkg;

    localparam int STORE_TYPE_SIZE = 2;

    localparam logic [STORE_TYPE_SIZE-1:0] ST_WORD = 2'd0;
    localparam logic [STORE_TYPE_SIZE-1:0] ST_HALF = 2'd1;
    localparam logic [STORE_TYPE_SIZE-1:0] ST_BYTE = 2'd2;

    localparam int SB_DEPTH = 4;

endpackage

// File: rtl/sb_match.sv
// Age-priority matcher for the store buffer load lookup.
// Ports:
//   valid     : per-entry valid bits
//   word_addr : per-entry word address (byte address [31:2])
//   st_type   : per-entry store type
//   head      : index of the oldest entry
//   ld_word   : word address of the load being looked up
//   hit       : youngest match is a full-word store (forwardable)
//   conflict  : youngest match is a narrower store (load must stall)
//   idx       : index of the youngest matching entry
module sb_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic [DEPTH-1:0]                      valid,
    input  logic [DEPTH-1:0][29:0]                word_addr,
    input  logic [DEPTH-1:0][STORE_TYPE_SIZE-1:0] st_type,
    input  logic [PTR_W-1:0]                      head,
    input  logic [29:0]                           ld_word,
    output logic                                  hit,
    output logic                                  conflict,
    output logic [PTR_W-1:0]                      idx
);

    logic             found;
    logic [PTR_W-1:0] pos;

    // Walk from oldest (head) to youngest; a later match overrides an
    // earlier one, so the final winner is the youngest matching store.
    // Valid entries are contiguous from head, so this order is age order.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        pos   = '0;
        for (int k = 0; k < DEPTH; k++) begin
            pos = head + PTR_W'(k);
            if (valid[pos] && (word_addr[pos] == ld_word)) begin
                found = 1'b1;
                idx   = pos;
            end
        end
        hit      = found && (st_type[idx] == ST_WORD);
        conflict = found && (st_type[idx] != ST_WORD);
    end

endmodule

// File: rtl/store_buffer.sv
// Posted-write store buffer between the EX/MEM register and data memory.
// Stores are queued in program order and drained one per cycle whenever the
// data memory write port is free; same-stage loads are forwarded from the
// youngest full-word match or stalled on a narrower overlapping store.
// Ports:
//   Clock, Reset (async, active-low)
//   St_*  : store request in, St_Ready back-pressure out
//   Ld_*  : load lookup in, hit/forwarded data/conflict out
//   DM_*  : head entry presented to the data memory, DM_Ready handshake in
//   Empty : no pending stores
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH = SB_DEPTH,
    parameter int PTR_W = 2
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       St_Valid,
    input  logic [31:0]                St_Addr,
    input  logic [31:0]                St_Data,
    input  logic [STORE_TYPE_SIZE-1:0] St_Type,
    input  logic [31:0]                St_WPC,
    output logic                       St_Ready,
    input  logic                       Ld_Valid,
    input  logic [31:0]                Ld_Addr,
    output logic                       Ld_Hit,
    output logic [31:0]                Ld_Data,
    output logic                       Ld_Conflict,
    output logic                       DM_Write,
    output logic [31:0]                DM_Addr,
    output logic [31:0]                DM_WD,
    output logic [STORE_TYPE_SIZE-1:0] DM_StoreType,
    output logic [31:0]                DM_WPC,
    input  logic                       DM_Ready,
    output logic                       Empty
);

    logic [DEPTH-1:0][31:0]                addr_q;
    logic [DEPTH-1:0][31:0]                data_q;
    logic [DEPTH-1:0][31:0]                wpc_q;
    logic [DEPTH-1:0][STORE_TYPE_SIZE-1:0] type_q;
    logic [DEPTH-1:0]                      valid_q;
    logic [DEPTH-1:0][29:0]                word_addr;

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;

    logic             push;
    logic             pop;
    logic             m_hit;
    logic             m_conflict;
    logic [PTR_W-1:0] m_idx;

    // Byte offset is irrelevant: matching is at word granularity.
    logic unused_ld_lsb;
    assign unused_ld_lsb = ^Ld_Addr[1:0];

    // Full/empty come from count only; head == tail is ambiguous.
    assign Empty    = (count == '0);
    assign St_Ready = (count != (PTR_W+1)'(DEPTH));
    assign DM_Write = !Empty;

    assign push = St_Valid && St_Ready;
    assign pop  = DM_Write && DM_Ready;

    assign DM_Addr      = addr_q[head];
    assign DM_WD        = data_q[head];
    assign DM_StoreType = type_q[head];
    assign DM_WPC       = wpc_q[head];

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            head    <= '0;
            tail    <= '0;
            count   <= '0;
            valid_q <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            // push and pop never target the same slot: that would need
            // head == tail with the buffer both non-empty and non-full.
            if (pop)  valid_q[head] <= 1'b0;
            if (push) valid_q[tail] <= 1'b1;
        end
    end

    // Payload storage carries no reset; valid_q qualifies every use.
    always_ff @(posedge Clock) begin
        if (push) begin
            addr_q[tail] <= St_Addr;
            data_q[tail] <= St_Data;
            type_q[tail] <= St_Type;
            wpc_q[tail]  <= St_WPC;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            word_addr[i] = addr_q[i][31:2];
        end
    end

    // Lookup sees registered entries only, including one being popped this
    // cycle, since its memory write lands on the same edge as the load.
    sb_match #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_match (
        .valid     (valid_q),
        .word_addr (word_addr),
        .st_type   (type_q),
        .head      (head),
        .ld_word   (Ld_Addr[31:2]),
        .hit       (m_hit),
        .conflict  (m_conflict),
        .idx       (m_idx)
    );

    assign Ld_Hit      = Ld_Valid && m_hit;
    assign Ld_Conflict = Ld_Valid && m_conflict;
    assign Ld_Data     = Ld_Hit ? data_q[m_idx] : 32'd0;

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

    localparam int DEPTH = 4;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  typ;
        logic [31:0] wpc;
    } st_rec_t;

    logic        Clock;
    logic        Reset;
    logic        St_Valid;
    logic [31:0] St_Addr;
    logic [31:0] St_Data;
    logic [1:0]  St_Type;
    logic [31:0] St_WPC;
    logic        St_Ready;
    logic        Ld_Valid;
    logic [31:0] Ld_Addr;
    logic        Ld_Hit;
    logic [31:0] Ld_Data;
    logic        Ld_Conflict;
    logic        DM_Write;
    logic [31:0] DM_Addr;
    logic [31:0] DM_WD;
    logic [1:0]  DM_StoreType;
    logic [31:0] DM_WPC;
    logic        DM_Ready;
    logic        Empty;

    int checks = 0;
    int errors = 0;

    // Reference model: the buffer contents as a plain program-order queue.
    st_rec_t mq[$];

    store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .St_Valid     (St_Valid),
        .St_Addr      (St_Addr),
        .St_Data      (St_Data),
        .St_Type      (St_Type),
        .St_WPC       (St_WPC),
        .St_Ready     (St_Ready),
        .Ld_Valid     (Ld_Valid),
        .Ld_Addr      (Ld_Addr),
        .Ld_Hit       (Ld_Hit),
        .Ld_Data      (Ld_Data),
        .Ld_Conflict  (Ld_Conflict),
        .DM_Write     (DM_Write),
        .DM_Addr      (DM_Addr),
        .DM_WD        (DM_WD),
        .DM_StoreType (DM_StoreType),
        .DM_WPC       (DM_WPC),
        .DM_Ready     (DM_Ready),
        .Empty        (Empty)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: inputs only change just after a rising edge, so
    // at the falling edge they are exactly what the next edge will see.
    always @(negedge Clock) begin
        if (!Reset) begin
            chk("rst_empty", {31'd0, Empty}, 32'd1);
            chk("rst_st_ready", {31'd0, St_Ready}, 32'd1);
            chk("rst_dm_write", {31'd0, DM_Write}, 32'd0);
            chk("rst_ld_hit", {31'd0, Ld_Hit}, 32'd0);
            chk("rst_ld_conflict", {31'd0, Ld_Conflict}, 32'd0);
            chk("rst_ld_data", Ld_Data, 32'd0);
            mq.delete();
        end else begin
            logic    was_full;
            logic    e_hit;
            logic    e_conf;
            logic [31:0] e_data;
            st_rec_t h;

            was_full = (mq.size() == DEPTH);
            chk("empty", {31'd0, Empty}, {31'd0, mq.size() == 0});
            chk("st_ready", {31'd0, St_Ready}, {31'd0, !was_full});
            chk("dm_write", {31'd0, DM_Write}, {31'd0, mq.size() != 0});

            // Youngest matching store decides the load outcome.
            e_hit = 1'b0; e_conf = 1'b0; e_data = 32'd0;
            if (Ld_Valid) begin
                for (int i = mq.size() - 1; i >= 0; i--) begin
                    if (mq[i].addr[31:2] == Ld_Addr[31:2]) begin
                        if (mq[i].typ == 2'd0) begin
                            e_hit = 1'b1; e_data = mq[i].data;
                        end else begin
                            e_conf = 1'b1;
                        end
                        break;
                    end
                end
            end
            chk("ld_hit", {31'd0, Ld_Hit}, {31'd0, e_hit});
            chk("ld_conflict", {31'd0, Ld_Conflict}, {31'd0, e_conf});
            chk("ld_data", Ld_Data, e_data);

            if (mq.size() != 0 && DM_Ready) begin
                h = mq.pop_front();
                chk("dm_addr", DM_Addr, h.addr);
                chk("dm_wd", DM_WD, h.data);
                chk("dm_type", {30'd0, DM_StoreType}, {30'd0, h.typ});
                chk("dm_wpc", DM_WPC, h.wpc);
            end
            if (St_Valid && !was_full) begin
                h.addr = St_Addr; h.data = St_Data; h.typ = St_Type; h.wpc = St_WPC;
                mq.push_back(h);
            end
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    // Present a store and hold it until it is accepted (bounded).
    task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] t, input logic [31:0] pc);
        int   n;
        logic acc;
        n = 0;
        St_Valid = 1'b1; St_Addr = a; St_Data = d; St_Type = t; St_WPC = pc;
        do begin
            @(negedge Clock);
            acc = St_Ready;
            step();
            n++;
        end while (!acc && n < 50);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL store_accept: got not accepted, expected accepted within 50 cycles");
        end
        St_Valid = 1'b0;
    endtask

    task automatic wait_empty();
        int n;
        n = 0;
        while (Empty !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        chk("drain_timeout", {31'd0, Empty}, 32'd1);
    endtask

    initial begin
        Reset = 1'b0; St_Valid = 1'b0; St_Addr = '0; St_Data = '0; St_Type = '0;
        St_WPC = '0; Ld_Valid = 1'b0; Ld_Addr = '0; DM_Ready = 1'b0;
        step(); step();
        Reset = 1'b1;
        step();

        // 1: drain order and one-cycle visibility latency
        DM_Ready = 1'b1;
        chk("t1_pre_dm_write", {31'd0, DM_Write}, 32'd0);
        do_store(32'h10, 32'hA0, 2'd0, 32'h400);
        chk("t1_dm_write_rise", {31'd0, DM_Write}, 32'd1);
        chk("t1_dm_addr_first", DM_Addr, 32'h10);
        do_store(32'h14, 32'hA4, 2'd0, 32'h404);
        do_store(32'h18, 32'hA8, 2'd0, 32'h408);
        wait_empty();

        // 2: full / back-pressure
        DM_Ready = 1'b0;
        for (int i = 0; i < 4; i++)
            do_store(32'h100 + 32'(i * 4), 32'hB0 + 32'(i), 2'd0, 32'h500 + 32'(i * 4));
        chk("t2_full_ready", {31'd0, St_Ready}, 32'd0);
        St_Valid = 1'b1; St_Addr = 32'h110; St_Data = 32'hB4; St_Type = 2'd0; St_WPC = 32'h510;
        step();
        chk("t2_held_ready", {31'd0, St_Ready}, 32'd0);
        DM_Ready = 1'b1;
        step();
        chk("t2_after_pop_ready", {31'd0, St_Ready}, 32'd1);
        step();
        St_Valid = 1'b0;
        wait_empty();

        // 3: forward youngest full-word store
        DM_Ready = 1'b0;
        do_store(32'h20, 32'h11111111, 2'd0, 32'h600);
        do_store(32'h20, 32'h22222222, 2'd0, 32'h604);
        Ld_Valid = 1'b1; Ld_Addr = 32'h20;
        #1;
        chk("t3_fwd_hit", {31'd0, Ld_Hit}, 32'd1);
        chk("t3_fwd_data", Ld_Data, 32'h22222222);
        chk("t3_fwd_conflict", {31'd0, Ld_Conflict}, 32'd0);
        step();
        Ld_Valid = 1'b0;
        DM_Ready = 1'b1;
        wait_empty();

        // 4: partial-width overlap stalls until the entry drains
        DM_Ready = 1'b0;
        do_store(32'h31, 32'h000000AB, 2'd2, 32'h700);
        Ld_Valid = 1'b1; Ld_Addr = 32'h30;
        #1;
        chk("t4_conflict", {31'd0, Ld_Conflict}, 32'd1);
        chk("t4_no_hit", {31'd0, Ld_Hit}, 32'd0);
        DM_Ready = 1'b1;
        step();
        chk("t4_conflict_clear", {31'd0, Ld_Conflict}, 32'd0);
        chk("t4_hit_clear", {31'd0, Ld_Hit}, 32'd0);
        Ld_Valid = 1'b0;

        // 5: wrap with DM_Ready toggling every cycle
        DM_Ready = 1'b0;
        fork
            begin
                repeat (40) begin
                    step();
                    DM_Ready = ~DM_Ready;
                end
            end
            begin
                for (int i = 0; i < 10; i++)
                    do_store(32'h200 + 32'(i * 4), 32'hC0 + 32'(i), 2'(i % 3), 32'h800 + 32'(i * 4));
            end
        join
        DM_Ready = 1'b1;
        wait_empty();

        // 6: asynchronous reset with three pending stores
        DM_Ready = 1'b0;
        do_store(32'h300, 32'hD0, 2'd0, 32'h900);
        do_store(32'h304, 32'hD1, 2'd0, 32'h904);
        do_store(32'h308, 32'hD2, 2'd1, 32'h908);
        #2;
        Reset = 1'b0;
        #1;
        chk("t6_async_empty", {31'd0, Empty}, 32'd1);
        chk("t6_async_dm_write", {31'd0, DM_Write}, 32'd0);
        step();
        #1;
        Reset = 1'b1;
        DM_Ready = 1'b1;
        repeat (3) step();
        chk("t6_no_write_after", {31'd0, DM_Write}, 32'd0);

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            St_Valid = ($urandom_range(0, 99) < 60);
            St_Addr  = 32'h40 + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
            St_Data  = $urandom;
            St_Type  = 2'($urandom_range(0, 2));
            St_WPC   = 32'h1000 + 32'(c * 4);
            Ld_Valid = ($urandom_range(0, 1) == 1);
            Ld_Addr  = 32'h40 + 32'($urandom_range(0, 4) * 4) + 32'($urandom_range(0, 3));
            DM_Ready = ($urandom_range(0, 99) < 45);
            step();
        end
        St_Valid = 1'b0; Ld_Valid = 1'b0; DM_Ready = 1'b1;
        wait_empty();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
